// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle between axi_burst_master and a memory slave.
// Single ID, one outstanding burst, no user/qos/cache sidebands.
interface axi_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Command/stream to single-INCR-burst AXI4 initiator.
// One burst in flight; data beats pass straight through to the user.
module axi_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [DATA_W-1:0]   usr_wdata,
  input  logic [DATA_W/8-1:0] usr_wstrb,
  input  logic                usr_wvalid,
  output logic                usr_wready,
  output logic [DATA_W-1:0]   usr_rdata,
  output logic [1:0]          usr_rresp,
  output logic                usr_rlast,
  output logic                usr_rvalid,
  input  logic                usr_rready,
  output logic                done,
  output logic [1:0]          done_resp,
  output logic                done_err,
  axi_burst_master_if.master  axi
);

  typedef enum logic [2:0] {
    IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic              awvalid_q;
  logic              arvalid_q;
  logic [1:0]        resp_q;
  logic              err_q;
  logic [31:0]       tcnt_q;

  logic to;
  logic in_w;
  logic in_b;
  logic in_r;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic any_hs;
  logic cnt_last;
  logic r_end;

  assign to = (TIMEOUT != 0) &&
              (state != IDLE) &&
              (state != FIN) &&
              (tcnt_q == 32'(TIMEOUT));

  assign in_w = (state == WDATA) && !to;
  assign in_b = (state == WRESP) && !to;
  assign in_r = (state == RDATA) && !to;

  assign cnt_last = (beat_q == len_q);
  assign r_end    = axi.rlast || cnt_last;

  assign aw_hs  = axi.awvalid && axi.awready;
  assign w_hs   = in_w && usr_wvalid && axi.wready;
  assign b_hs   = in_b && axi.bvalid;
  assign ar_hs  = axi.arvalid && axi.arready;
  assign r_hs   = in_r && axi.rvalid && usr_rready;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q && !to;

  assign axi.wdata  = usr_wdata;
  assign axi.wstrb  = usr_wstrb;
  assign axi.wlast  = cnt_last;
  assign axi.wvalid = in_w && usr_wvalid;
  assign usr_wready = in_w && axi.wready;

  assign axi.bready = in_b;

  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q && !to;

  assign axi.rready = in_r && usr_rready;
  assign usr_rvalid = in_r && axi.rvalid;
  assign usr_rdata  = axi.rdata;
  assign usr_rresp  = axi.rresp;
  assign usr_rlast  = axi.rlast;

  assign cmd_ready = (state == IDLE);
  assign done      = (state == FIN);
  assign done_resp = done ? resp_q : 2'b00;
  assign done_err  = done && err_q;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: handshake-driven walk, timeout forces FIN.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) state_n = cmd_write ? WADDR : RADDR;
      end
      WADDR: if (aw_hs) state_n = WDATA;
      WDATA: if (w_hs && cnt_last) state_n = WRESP;
      WRESP: if (b_hs) state_n = FIN;
      RADDR: if (ar_hs) state_n = RDATA;
      RDATA: if (r_hs && r_end) state_n = FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (to) state_n = FIN;
  end

  // Command latch, beat counter, address valids and response fold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      resp_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      if (cmd_ready && cmd_valid) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        beat_q <= '0;
        resp_q <= 2'b00;
        err_q  <= 1'b0;
      end
      awvalid_q <= (state == WADDR) && !aw_hs && !to;
      arvalid_q <= (state == RADDR) && !ar_hs && !to;
      if (w_hs) beat_q <= beat_q + 8'd1;
      if (b_hs) resp_q <= axi.bresp;
      if (r_hs) begin
        beat_q <= beat_q + 8'd1;
        if (axi.rresp > resp_q) resp_q <= axi.rresp;
        if (axi.rlast != cnt_last) err_q <= 1'b1;
      end
      if (to) begin
        resp_q <= 2'b10;
        err_q  <= 1'b1;
      end
    end
  end

  // Stall watchdog: cleared by any progress, saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (state == IDLE || state_n != state || any_hs) begin
      tcnt_q <= '0;
    end else if (tcnt_q != 32'(TIMEOUT)) begin
      tcnt_q <= tcnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural memory slave, word model,
// table of bursts with random throttling, plus corner-case sequences.
module tb_axi_burst_master;

  localparam int TO = 64;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] usr_wdata;
  logic [3:0]  usr_wstrb;
  logic        usr_wvalid;
  logic        usr_wready;
  logic [31:0] usr_rdata;
  logic [1:0]  usr_rresp;
  logic        usr_rlast;
  logic        usr_rvalid;
  logic        usr_rready;
  logic        done;
  logic [1:0]  done_resp;
  logic        done_err;

  axi_burst_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_burst_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .usr_wdata(usr_wdata),
    .usr_wstrb(usr_wstrb),
    .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready),
    .usr_rdata(usr_rdata),
    .usr_rresp(usr_rresp),
    .usr_rlast(usr_rlast),
    .usr_rvalid(usr_rvalid),
    .usr_rready(usr_rready),
    .done(done),
    .done_resp(done_resp),
    .done_err(done_err),
    .axi(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave bus model ----------------
  logic        aw_block;
  int          r_last_at;
  int          r_err_at;
  logic [31:0] mem [0:1023];
  logic [31:0] s_waddr;
  logic [7:0]  s_awlen;
  int          s_wcnt;
  logic        s_wlast_bad;
  logic        s_ract;
  logic [31:0] s_raddr;
  logic [7:0]  s_arlen;
  int          s_rcnt;
  logic        s_arlen_bad;
  int          r_nidx;

  function automatic logic [9:0] widx(input logic [31:0] a, input int n);
    return a[11:2] + n[9:0];
  endfunction

  function automatic logic [31:0] smask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  assign r_nidx = s_rcnt + ((bus.rvalid && bus.rready) ? 1 : 0);

  // Memory responder with random ready/valid throttling.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= 2'b00;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= 2'b00;
      bus.rlast   <= 1'b0;
      s_waddr     <= '0;
      s_awlen     <= '0;
      s_wcnt      <= 0;
      s_wlast_bad <= 1'b0;
      s_ract      <= 1'b0;
      s_raddr     <= '0;
      s_arlen     <= '0;
      s_rcnt      <= 0;
      s_arlen_bad <= 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      bus.awready <= !aw_block && ($urandom_range(0, 1) == 1);
      if (bus.awvalid && bus.awready) begin
        s_waddr     <= bus.awaddr;
        s_awlen     <= bus.awlen;
        s_wcnt      <= 0;
        s_wlast_bad <= 1'b0;
      end
      bus.wready <= ($urandom_range(0, 1) == 1);
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (bus.wvalid && bus.wready) begin
        mem[widx(s_waddr, s_wcnt)] <=
          (mem[widx(s_waddr, s_wcnt)] & ~smask(bus.wstrb)) |
          (bus.wdata & smask(bus.wstrb));
        if (bus.wlast != (s_wcnt == int'(s_awlen))) s_wlast_bad <= 1'b1;
        s_wcnt <= s_wcnt + 1;
        if (s_wcnt == int'(s_awlen)) begin
          bus.bvalid <= 1'b1;
          bus.bresp  <= 2'b00;
        end
      end
      bus.arready <= !s_ract && ($urandom_range(0, 1) == 1);
      if (bus.arvalid && bus.arready) begin
        s_ract      <= 1'b1;
        s_raddr     <= bus.araddr;
        s_arlen     <= bus.arlen;
        s_rcnt      <= 0;
        s_arlen_bad <= 1'b0;
      end
      if (s_ract && bus.arlen != s_arlen) s_arlen_bad <= 1'b1;
      if (bus.rvalid && bus.rready) begin
        s_rcnt <= s_rcnt + 1;
        if (bus.rlast) s_ract <= 1'b0;
      end
      if (!bus.rvalid || bus.rready) begin
        if (s_ract && !(bus.rvalid && bus.rready && bus.rlast) &&
            $urandom_range(0, 3) != 0) begin
          bus.rvalid <= 1'b1;
          bus.rdata  <= mem[widx(s_raddr, r_nidx)];
          bus.rresp  <= (r_nidx == r_err_at) ? 2'b10 : 2'b00;
          bus.rlast  <= (r_nidx == int'(s_arlen)) || (r_nidx == r_last_at);
        end else begin
          bus.rvalid <= 1'b0;
          bus.rlast  <= 1'b0;
        end
      end
    end
  end

  // ---------------- reference model and checks ----------------
  logic [31:0] exp_mem [0:1023];
  logic [31:0] wd [$];
  logic [31:0] rd_data [$];
  logic [1:0]  rd_resp [$];
  logic        rd_last [$];
  int          total;
  int          bad;
  logic        d_seen;
  logic [1:0]  d_resp;
  logic        d_err;
  logic [7:0]  d_arlen;
  int          d_pulses;
  int          d_cycles;
  int          w_acc;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  strb;
    int          rmode;
    logic        rnd;
    logic [31:0] base;
    logic [1:0]  exp_resp;
    logic        exp_err;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic count_pulses();
    d_pulses = d_seen ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (done) d_pulses++;
    end
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] a,
                        input logic [7:0] l);
    chk("cmd_ready idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] a, input logic [7:0] l,
                           input logic [3:0] s);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    d_seen = 1'b0;
    do_cmd(1'b1, a, l);
    while (!d_seen && cyc < 4000) begin
      if (done) begin
        d_seen = 1'b1;
        d_resp = done_resp;
        d_err  = done_err;
      end else begin
        usr_wvalid = (i <= int'(l)) && ($urandom_range(0, 3) != 0);
        usr_wdata  = (i <= int'(l)) ? wd[i] : 32'h0;
        usr_wstrb  = s;
        #1;
        if (usr_wvalid && usr_wready) i++;
        @(negedge clk);
        cyc++;
      end
    end
    usr_wvalid = 1'b0;
    w_acc = i;
    d_cycles = cyc;
    count_pulses();
    for (int k = 0; k <= int'(l); k++)
      exp_mem[(int'(a >> 2) + k) % 1024] =
        merge(exp_mem[(int'(a >> 2) + k) % 1024], wd[k], s);
  endtask

  task automatic run_read(input logic [31:0] a, input logic [7:0] l,
                          input int mode);
    int cyc;
    cyc = 0;
    d_seen = 1'b0;
    rd_data.delete();
    rd_resp.delete();
    rd_last.delete();
    do_cmd(1'b0, a, l);
    while (!d_seen && cyc < 4000) begin
      if (done) begin
        d_seen  = 1'b1;
        d_resp  = done_resp;
        d_err   = done_err;
        d_arlen = bus.arlen;
      end else begin
        case (mode)
          0:       usr_rready = (cyc % 2) == 0;
          1:       usr_rready = ($urandom_range(0, 1) == 1);
          default: usr_rready = 1'b1;
        endcase
        #1;
        if (usr_rvalid && usr_rready) begin
          rd_data.push_back(usr_rdata);
          rd_resp.push_back(usr_rresp);
          rd_last.push_back(usr_rlast);
        end
        @(negedge clk);
        cyc++;
      end
    end
    usr_rready = 1'b0;
    d_cycles = cyc;
    count_pulses();
  endtask

  initial begin
    int cyc;
    int i;
    logic saw_av;
    logic d_av;
    total = 0;
    bad = 0;
    tbl[0] = '{32'h10,  8'd3,   4'hF, 0, 1'b0, 32'hA0, 2'b00, 1'b0};
    tbl[1] = '{32'h40,  8'd0,   4'hF, 1, 1'b1, 32'h0,  2'b00, 1'b0};
    tbl[2] = '{32'h80,  8'd15,  4'hA, 1, 1'b1, 32'h0,  2'b00, 1'b0};
    tbl[3] = '{32'h100, 8'd7,   4'h3, 0, 1'b1, 32'h0,  2'b00, 1'b0};
    tbl[4] = '{32'h400, 8'd255, 4'hF, 2, 1'b0, 32'h1000, 2'b00, 1'b0};
    for (int k = 0; k < 1024; k++) exp_mem[k] = '0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    usr_wdata = '0;
    usr_wstrb = '0;
    usr_wvalid = 1'b0;
    usr_rready = 1'b0;
    aw_block = 1'b0;
    r_last_at = -1;
    r_err_at = -1;
    repeat (3) @(negedge clk);

    chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst valids", {23'd0, bus.awvalid, bus.wvalid, bus.bready,
        bus.arvalid, bus.rready, usr_wready, usr_rvalid, done,
        done_err}, 32'd0);
    chk("rst done_resp", {30'd0, done_resp}, 32'd0);
    chk("rst latched addr", bus.awaddr, 32'd0);
    chk("rst latched len", {24'd0, bus.arlen}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      wd.delete();
      for (int k = 0; k <= int'(tbl[t].len); k++)
        wd.push_back(tbl[t].rnd ? $urandom : tbl[t].base + k);
      run_write(tbl[t].addr, tbl[t].len, tbl[t].strb);
      chk("wr done seen", {31'd0, d_seen}, 32'd1);
      chk("wr done_resp", {30'd0, d_resp}, {30'd0, tbl[t].exp_resp});
      chk("wr done_err", {31'd0, d_err}, {31'd0, tbl[t].exp_err});
      chk("wr done pulses", d_pulses, 32'd1);
      chk("wr user beats", w_acc, int'(tbl[t].len) + 1);
      chk("wr bus beats", s_wcnt, int'(tbl[t].len) + 1);
      chk("wr wlast place", {31'd0, s_wlast_bad}, 32'd0);

      run_read(tbl[t].addr, tbl[t].len, tbl[t].rmode);
      chk("rd done seen", {31'd0, d_seen}, 32'd1);
      chk("rd done_resp", {30'd0, d_resp}, {30'd0, tbl[t].exp_resp});
      chk("rd done_err", {31'd0, d_err}, {31'd0, tbl[t].exp_err});
      chk("rd done pulses", d_pulses, 32'd1);
      chk("rd beats", rd_data.size(), int'(tbl[t].len) + 1);
      for (int k = 0; k < rd_data.size(); k++) begin
        chk("rd data", rd_data[k],
            exp_mem[(int'(tbl[t].addr >> 2) + k) % 1024]);
        chk("rd rlast", {31'd0, rd_last[k]},
            {31'd0, k == int'(tbl[t].len)});
      end
      chk("arlen at done", {24'd0, d_arlen}, {24'd0, tbl[t].len});
      chk("arlen held", {31'd0, s_arlen_bad}, 32'd0);
    end

    wd.delete();
    wd.push_back(32'hDEADBEEF);
    run_write(32'h200, 8'd0, 4'b0101);
    chk("strb done_resp", {30'd0, d_resp}, 32'd0);
    chk("len0 bus beats", s_wcnt, 32'd1);
    chk("len0 wlast first", {31'd0, s_wlast_bad}, 32'd0);
    run_read(32'h200, 8'd0, 2);
    chk("strb beats", rd_data.size(), 32'd1);
    if (rd_data.size() > 0) begin
      chk("strb merge", rd_data[0], 32'h00AD00EF);
      chk("strb rlast", {31'd0, rd_last[0]}, 32'd1);
    end

    r_last_at = 2;
    run_read(32'h10, 8'd3, 1);
    r_last_at = -1;
    chk("early rlast seen", {31'd0, d_seen}, 32'd1);
    chk("early rlast beats", rd_data.size(), 32'd3);
    chk("early rlast err", {31'd0, d_err}, 32'd1);
    chk("early rlast resp", {30'd0, d_resp}, 32'd0);
    if (rd_data.size() > 2)
      chk("early rlast data", rd_data[2], exp_mem[6]);

    r_err_at = 1;
    run_read(32'h10, 8'd3, 2);
    r_err_at = -1;
    chk("rresp beats", rd_data.size(), 32'd4);
    chk("rresp done_resp", {30'd0, d_resp}, 32'd2);
    chk("rresp done_err", {31'd0, d_err}, 32'd0);
    if (rd_resp.size() > 1)
      chk("rresp beat1", {30'd0, rd_resp[1]}, 32'd2);

    aw_block = 1'b1;
    do_cmd(1'b1, 32'h300, 8'd0);
    cyc = 0;
    d_seen = 1'b0;
    saw_av = 1'b0;
    d_av = 1'b1;
    while (!d_seen && cyc < 400) begin
      if (done) begin
        d_seen = 1'b1;
        d_resp = done_resp;
        d_err  = done_err;
        d_av   = bus.awvalid;
      end else begin
        if (bus.awvalid) saw_av = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    chk("timeout done seen", {31'd0, d_seen}, 32'd1);
    chk("timeout awvalid up", {31'd0, saw_av}, 32'd1);
    chk("timeout awvalid drop", {31'd0, d_av}, 32'd0);
    chk("timeout done_resp", {30'd0, d_resp}, 32'd2);
    chk("timeout done_err", {31'd0, d_err}, 32'd1);
    chk("timeout latency", {31'd0, cyc >= TO}, 32'd1);
    count_pulses();
    chk("timeout pulses", d_pulses, 32'd1);
    aw_block = 1'b0;

    wd.delete();
    for (int k = 0; k < 8; k++) wd.push_back(32'h5A00 + k);
    do_cmd(1'b1, 32'h800, 8'd7);
    i = 0;
    cyc = 0;
    usr_wvalid = 1'b1;
    usr_wstrb = 4'hF;
    while (i < 2 && cyc < 200) begin
      usr_wdata = wd[i];
      #1;
      if (usr_wready) i++;
      @(negedge clk);
      cyc++;
    end
    usr_wdata = wd[i];
    #1;
    chk("beats before rst", i, 32'd2);
    chk("wvalid before rst", {31'd0, bus.wvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("valids in rst", {25'd0, bus.awvalid, bus.wvalid, bus.bready,
        bus.arvalid, bus.rready, usr_wready, usr_rvalid}, 32'd0);
    @(negedge clk);
    usr_wvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("cmd_ready after rst", {31'd0, cmd_ready}, 32'd1);
    chk("done after rst", {31'd0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
AXI4 full-protocol initiator that converts a simple command/stream user interface into single INCR bursts on the AW/W/B or AR/R channels. It is the counterpart of the team's axi_slave memory responder: 32-bit data, one outstanding transaction, no IDs. User logic issues one command, streams write data in or receives read data out, and gets a one-cycle completion pulse with the response code.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width; fixed at 32, so AxSIZE = 3'b010
TIMEOUT, 1024, cycles a handshake may stall before the transaction aborts; 0 disables

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  burst start address, word aligned
cmd_len  input  8  beats minus 1 (AXI LEN encoding)
usr_wdata  input  32  write data stream
usr_wstrb  input  4  write byte strobes
usr_wvalid  input  1  write data valid
usr_wready  output  1  write data accepted
usr_rdata  output  32  read data stream
usr_rresp  output  2  per-beat RRESP
usr_rlast  output  1  last read beat
usr_rvalid  output  1  read data valid
usr_rready  input  1  user can take read data
done  output  1  one-cycle completion pulse
done_resp  output  2  final response; valid while done = 1
done_err  output  1  protocol or timeout error; valid while done = 1
AW*: AWADDR[31:0], AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWVALID out; AWREADY in
W*: WDATA[31:0], WSTRB[3:0], WLAST, WVALID out; WREADY in
B*: BRESP[1:0], BVALID in; BREADY out
AR*: ARADDR[31:0], ARLEN[7:0], ARSIZE[2:0], ARBURST[1:0], ARVALID out; ARREADY in
R*: RDATA[31:0], RRESP[1:0], RLAST, RVALID in; RREADY out

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - AWVALID, WVALID, BREADY, ARVALID, RREADY, done, done_err, usr_wready, usr_rvalid = 0.
  - done_resp = 0; beat counter = 0; latched addr/len = 0.
  - A reset mid-burst abandons the burst immediately. The slave must be reset together with the master.
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr, len and write.
  - Next state is WADDR if write, else RADDR.
  - Beat counter and error accumulators clear.
- Address channels:
  - AxADDR and AxLEN are driven from the latched values and held stable from command acceptance until FIN. The slave samples ARLEN during the data phase.
  - AxSIZE = 3'b010 and AxBURST = 2'b01 are constant.
  - AxVALID is registered and asserts the cycle after entering the state.
  - AxVALID stays high until it is sampled with AxREADY on a rising edge. It then drops, and the FSM moves to WDATA or RDATA.
- WDATA (combinational pass-through):
  - WVALID = usr_wvalid; usr_wready = WREADY.
  - WDATA and WSTRB pass straight from the user stream.
  - WLAST = (beat counter == latched len).
  - Each WVALID & WREADY edge increments the beat counter.
  - The beat with WLAST moves the FSM to WRESP.
- WRESP:
  - BREADY = 1.
  - On BVALID, capture BRESP and go to FIN.
- RDATA (pass-through):
  - RREADY = usr_rready; usr_rvalid = RVALID; usr_rdata/usr_rresp/usr_rlast = RDATA/RRESP/RLAST.
  - Each RVALID & RREADY beat increments the counter and folds RRESP into a worst-case accumulator (max of codes).
  - Burst ends on a handshake with RLAST = 1, or with counter == len, whichever comes first.
  - If RLAST and counter == len disagree on that beat, set done_err.
- FIN:
  - done = 1 for exactly one cycle.
  - done_resp = BRESP (write) or accumulated RRESP (read).
  - Next state IDLE.
- Timeout:
  - A counter resets on every state change and on every handshake.
  - If it reaches TIMEOUT in any non-IDLE state, all VALID/READY outputs drop, done_err = 1, done_resp = 2'b10, and the FSM goes to FIN.
- Boundaries and fixed decisions:
  - len = 0 gives a single beat with WLAST high on the first beat.
  - len = 255 gives 256 beats; the counter is 8 bits and must not wrap before the last beat.
  - Crossing a 4 KB boundary is not checked; the caller is responsible.
  - cmd_valid outside IDLE is ignored.
  - Write data presented before WDATA is not accepted.

Test Plan:
- Write burst: cmd_addr 0x10, len 3, data A0..A3, strobes 4'hF, axi_slave attached -> exactly 4 W beats with WLAST only on A3; BREADY taken; done = 1 with done_resp 00, done_err 0; slave words 4..7 = A0..A3.
- Read back: read 0x10, len 3, usr_rready toggling 1/0 -> usr_rdata A0..A3 in order, usr_rlast on the 4th beat only; ARLEN = 3 held until done; done_resp 00.
- Partial strobes: single-beat write of 0xDEADBEEF with wstrb 4'b0101 to a word holding 0 -> word reads 0x00AD00EF; len 0 gives WLAST on the first beat.
- Max burst: write then read of 256 beats, incrementing data -> all 256 words match; beat counter does not wrap early; one done pulse per burst.
- Protocol error: bus model asserts RLAST on beat 2 of a len 3 read -> burst ends; done_err = 1. Bus model returns RRESP 10 on one beat -> done_resp = 10.
- Timeout and reset: AWREADY held low for TIMEOUT cycles -> AWVALID drops, done with done_resp 10 and done_err 1. Reset asserted mid-write -> all valids 0 in the same cycle and cmd_ready = 1 after release.
